// File: rtl/vga_mon_pkg.sv
// Shared types, 640x480 timing constants and helpers for the VGA timing monitor.
package vga_mon_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_e;

  localparam int H_TOTAL_640 = 800;
  localparam int H_SYNC_640  = 96;
  localparam int V_TOTAL_480 = 525;
  localparam int V_SYNC_480  = 2;

  function automatic logic [15:0] rotl1(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

endpackage

// File: rtl/vga_period_meter.sv
// Generic sync period / pulse-width meter: counts inc events between leading
// edges and the events seen while the sync is active; both counters saturate.
module vga_period_meter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             edge_i,
  input  logic             active_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] pulse_o,
  output logic [WIDTH-1:0] period_d_o,
  output logic [WIDTH-1:0] pulse_d_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == MAX) ? MAX : v + ONE;
  endfunction

  // An inc coinciding with the edge closes the old interval; an active inc
  // on that same tick opens the new pulse count.
  always_comb begin
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    period_d = period_q;
    pulse_d  = pulse_q;
    if (edge_i) begin
      period_d = inc_i ? sat_inc(cnt_q) : cnt_q;
      pulse_d  = pcnt_q;
      cnt_d    = '0;
      pcnt_d   = (inc_i && active_i) ? ONE : '0;
    end else if (inc_i) begin
      cnt_d = sat_inc(cnt_q);
      if (active_i) begin
        pcnt_d = sat_inc(pcnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
      pulse_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      pulse_q  <= pulse_d;
    end
  end

  assign period_o   = period_q;
  assign pulse_o    = pulse_q;
  assign period_d_o = period_d;
  assign pulse_d_o  = pulse_d;

endmodule

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA checker: measures line/frame timing against the expected
// mode, builds a per-frame RGB signature and reports lock and sticky errors.
module vga_timing_monitor
  import vga_mon_pkg::*;
#(
  parameter int H_TOTAL_EXP = H_TOTAL_640,
  parameter int H_SYNC_EXP  = H_SYNC_640,
  parameter int V_TOTAL_EXP = V_TOTAL_480,
  parameter int V_SYNC_EXP  = V_SYNC_480,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic [3:0]  vgaRed,
  input  logic [3:0]  vgaGreen,
  input  logic [3:0]  vgaBlue,
  input  logic        err_clr,
  output logic        locked,
  output logic        frame_done,
  output logic [11:0] h_total,
  output logic [11:0] h_pulse,
  output logic [10:0] v_total,
  output logic [10:0] v_pulse,
  output logic [15:0] frame_sum,
  output logic        h_err,
  output logic        v_err
);

  localparam logic ACT = (SYNC_POL != 0);
  localparam int   MW  = $clog2(LOCK_FRAMES + 1);

  logic        tick_q;
  logic        hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic [11:0] rgb_q;
  logic        hs_lead, vs_lead;

  logic [11:0] h_tot_d, h_pul_d;
  logic [10:0] v_tot_d, v_pul_d;
  logic        h_ok, v_ok, checking;
  logic        h_err_q, h_err_d, v_err_q, v_err_d;

  mon_state_e  state_q;
  logic [MW-1:0] match_q;
  logic        fd_q;
  logic [15:0] acc_q, sum_q;

  // Syncs are normalised to an active-high flag; tick_q marks the cycle in
  // which the freshly registered sample is evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= 1'b0;
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      tick_q <= pix_en;
      if (pix_en) begin
        hs_q      <= (Hsync == ACT);
        hs_prev_q <= hs_q;
        vs_q      <= (Vsync == ACT);
        vs_prev_q <= vs_q;
        rgb_q     <= {vgaRed, vgaGreen, vgaBlue};
      end
    end
  end

  assign hs_lead = tick_q && hs_q && !hs_prev_q;
  assign vs_lead = tick_q && vs_q && !vs_prev_q;

  vga_period_meter #(.WIDTH(12)) u_h_meter (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (tick_q),
    .edge_i     (hs_lead),
    .active_i   (hs_q),
    .period_o   (h_total),
    .pulse_o    (h_pulse),
    .period_d_o (h_tot_d),
    .pulse_d_o  (h_pul_d)
  );

  vga_period_meter #(.WIDTH(11)) u_v_meter (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (hs_lead),
    .edge_i     (vs_lead),
    .active_i   (vs_q),
    .period_o   (v_total),
    .pulse_o    (v_pulse),
    .period_d_o (v_tot_d),
    .pulse_d_o  (v_pul_d)
  );

  // Compare the values being latched this tick, so a coincident H/V edge
  // is judged on the fresh measurement.
  assign h_ok     = (h_tot_d == 12'(H_TOTAL_EXP)) && (h_pul_d == 12'(H_SYNC_EXP));
  assign v_ok     = (v_tot_d == 11'(V_TOTAL_EXP)) && (v_pul_d == 11'(V_SYNC_EXP));
  assign checking = (state_q != ST_SEARCH);

  always_comb begin
    h_err_d = h_err_q;
    v_err_d = v_err_q;
    if (err_clr) begin
      h_err_d = 1'b0;
      v_err_d = 1'b0;
    end
    if (checking && hs_lead && !h_ok) begin
      h_err_d = 1'b1;
    end
    if (checking && vs_lead && !v_ok) begin
      v_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_err_q <= 1'b0;
      v_err_q <= 1'b0;
    end else begin
      h_err_q <= h_err_d;
      v_err_q <= v_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      sum_q <= '0;
    end else if (tick_q) begin
      if (vs_lead) begin
        sum_q <= acc_q;
        acc_q <= {4'h0, rgb_q};
      end else begin
        acc_q <= rotl1(acc_q) ^ {4'h0, rgb_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SEARCH;
      match_q <= '0;
      fd_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          if (vs_lead) begin
            state_q <= ST_MEASURE;
            match_q <= '0;
          end
        end
        ST_MEASURE: begin
          if (vs_lead) begin
            fd_q <= 1'b1;
            if (h_ok && v_ok) begin
              if (match_q == MW'(LOCK_FRAMES - 1)) begin
                state_q <= ST_LOCKED;
                match_q <= '0;
              end else begin
                match_q <= match_q + MW'(1);
              end
            end else begin
              match_q <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (vs_lead) begin
            fd_q <= 1'b1;
          end
          if ((hs_lead && !h_ok) || (vs_lead && !(h_ok && v_ok))) begin
            state_q <= ST_MEASURE;
            match_q <= '0;
          end
        end
        default: begin
          state_q <= ST_SEARCH;
          match_q <= '0;
        end
      endcase
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign frame_done = fd_q;
  assign frame_sum  = sum_q;
  assign h_err      = h_err_q;
  assign v_err      = v_err_q;

endmodule
